// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b front-end types and sizing constants.
//
// Contents:
//   IQ_DEPTH           default instruction-queue depth. Fetch and decode
//                      both size against this constant so they agree.
//   lc3b_iqueue_entry  one fetched instruction as handed from fetch to decode:
//                        pc          address of the instruction
//                        instruction raw 16-bit instruction word
//                        prediction  branch predicted taken by fetch
package lc3b_types;

    localparam int IQ_DEPTH = 8;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instruction;
        logic        prediction;
    } lc3b_iqueue_entry;

endpackage

// File: rtl/instruction_queue.sv
// instruction_queue: circular FIFO between fetch and decode/issue.
//
// Absorbs fetch bursts and holds the head entry stable while decode stalls.
// The whole queue is discarded on flush (mispredict / ROB recovery).
//
// Parameters:
//   DEPTH     number of entries (power of two, >= 2)
//   PTR_W     head/tail pointer width, derived from DEPTH
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   rst_n     synchronous active-low reset
//   flush     discard all entries; same-cycle push/pop are ignored
//   push      fetch presents a valid entry on data_in
//   data_in   entry from fetch
//   full      no free slot (push only allowed with a same-cycle pop)
//   pop       decode consumed the head entry
//   data_out  head entry, meaningful only while valid=1
//   valid     queue holds at least one entry
//   count     current occupancy, 0..DEPTH
//
// Build option:
//   IQ_BYPASS_EN  when defined, a push into an empty queue is presented on
//                 data_out/valid in the same cycle; if decode pops it in that
//                 cycle it is never written. When undefined there is no
//                 combinational path from push/data_in to data_out/valid.
module instruction_queue
    import lc3b_types::*;
#(
    parameter int  DEPTH = IQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  lc3b_iqueue_entry data_in,
    output logic             full,
    input  logic             pop,
    output lc3b_iqueue_entry data_out,
    output logic             valid,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

    lc3b_iqueue_entry storage [DEPTH];

    logic [PTR_W-1:0] head_reg;
    logic [PTR_W-1:0] tail_reg;
    logic [PTR_W:0]   occ_reg;

    logic empty;
    logic push_ok;
    logic pop_ok;
    logic bypass_take;  // entry passed straight through, never stored
    logic wr_en;
    logic rd_adv;

    // ------------------------------------------------------------------
    // Status and head outputs
    // ------------------------------------------------------------------
    always_comb begin
        empty = (occ_reg == '0);
        full  = (occ_reg == DEPTH_CNT);
        count = occ_reg;
`ifdef IQ_BYPASS_EN
        valid    = !empty || push;
        data_out = (empty && push) ? data_in : storage[head_reg];
`else
        valid    = !empty;
        data_out = storage[head_reg];
`endif
    end

    // ------------------------------------------------------------------
    // Accept rules
    // ------------------------------------------------------------------
    always_comb begin
        pop_ok  = pop && valid;
        push_ok = push && (!full || pop_ok);
`ifdef IQ_BYPASS_EN
        // Empty queue, pushed and popped together: the entry goes straight
        // to decode, so neither pointer moves and nothing is written.
        bypass_take = empty && push && pop;
`else
        bypass_take = 1'b0;
`endif
        wr_en  = rst_n && !flush && push_ok && !bypass_take;
        rd_adv = rst_n && !flush && pop_ok  && !bypass_take;
    end

    // ------------------------------------------------------------------
    // Pointers and occupancy. Pointers are PTR_W bits wide, so they wrap
    // from DEPTH-1 to 0 on their own.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else if (flush) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= '0;
        end else begin
            if (wr_en) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (rd_adv) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({wr_en, rd_adv})
                2'b10:   occ_reg <= occ_reg + 1'b1;
                2'b01:   occ_reg <= occ_reg - 1'b1;
                default: occ_reg <= occ_reg;
            endcase
        end
    end

    // Storage has no reset so it maps onto distributed/block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            storage[tail_reg] <= data_in;
        end
    end

endmodule
